// File: rtl/mtl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : mtl_pkg                                                          |
// | Purpose  : MTL 800x480 panel timing defaults and shared coordinate types.   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
package mtl_pkg;

    localparam int MTL_H_ACTIVE = 800;
    localparam int MTL_H_FRONT  = 210;
    localparam int MTL_H_SYNC   = 30;
    localparam int MTL_H_BACK   = 16;
    localparam int MTL_V_ACTIVE = 480;
    localparam int MTL_V_FRONT  = 22;
    localparam int MTL_V_SYNC   = 13;
    localparam int MTL_V_BACK   = 10;

    localparam int MTL_H_TOTAL = MTL_H_ACTIVE + MTL_H_FRONT + MTL_H_SYNC + MTL_H_BACK;
    localparam int MTL_V_TOTAL = MTL_V_ACTIVE + MTL_V_FRONT + MTL_V_SYNC + MTL_V_BACK;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    typedef logic [X_W-1:0] xcoord_t;
    typedef logic [Y_W-1:0] ycoord_t;

    // Strobes carried through the alignment delay line (MSB first).
    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic data_en;
    } strobe_t;

    localparam strobe_t STROBE_RST = '{hsync_n: 1'b1, vsync_n: 1'b1, data_en: 1'b0};

endpackage
`default_nettype wire

// File: rtl/sync_delay_line.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : sync_delay_line                                                  |
// | Purpose  : Enable-gated shift register of configurable width and depth.     |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module sync_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    generate
        if (DEPTH == 0) begin : g_passthru
            logic w_unused;
            assign w_unused = ^{clk, reset, en_i};
            assign data_o   = data_i;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RST_VAL;
                    end
                end else if (en_i) begin
                    stage_q[0] <= data_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign data_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mtl_timing_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : mtl_timing_gen                                                   |
// | Purpose  : Raster counters, active-area coordinates and delayed panel sync. |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module mtl_timing_gen
    import mtl_pkg::*;
#(
    parameter int H_ACTIVE = MTL_H_ACTIVE,
    parameter int H_FRONT  = MTL_H_FRONT,
    parameter int H_SYNC   = MTL_H_SYNC,
    parameter int H_BACK   = MTL_H_BACK,
    parameter int V_ACTIVE = MTL_V_ACTIVE,
    parameter int V_FRONT  = MTL_V_FRONT,
    parameter int V_SYNC   = MTL_V_SYNC,
    parameter int V_BACK   = MTL_V_BACK,
    parameter int PIPE_DLY = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    enable,
    output xcoord_t Xpos,
    output ycoord_t Ypos,
    output logic    data_en,
    output logic    data_en_dly,
    output logic    hsync_n,
    output logic    vsync_n,
    output logic    line_start,
    output logic    frame_start
);

    localparam int c_h_total = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_hw      = $clog2(c_h_total);
    localparam int c_vw      = $clog2(c_v_total);

    localparam logic [c_hw-1:0] c_h_last     = c_hw'(c_h_total - 1);
    localparam logic [c_hw-1:0] c_h_sync_end = c_hw'(H_SYNC);
    localparam logic [c_hw-1:0] c_h_act_beg  = c_hw'(H_SYNC + H_BACK);
    localparam logic [c_hw-1:0] c_h_act_end  = c_hw'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [c_vw-1:0] c_v_last     = c_vw'(c_v_total - 1);
    localparam logic [c_vw-1:0] c_v_sync_end = c_vw'(V_SYNC);
    localparam logic [c_vw-1:0] c_v_act_beg  = c_vw'(V_SYNC + V_BACK);
    localparam logic [c_vw-1:0] c_v_act_end  = c_vw'(V_SYNC + V_BACK + V_ACTIVE);

    logic [c_hw-1:0] h_cnt_q, h_cnt_d;
    logic [c_vw-1:0] v_cnt_q, v_cnt_d;
    xcoord_t         xpos_q, xpos_d;
    ycoord_t         ypos_q, ypos_d;
    logic            de_q, de_d;
    logic            hs_raw_q, hs_raw_d;
    logic            vs_raw_q, vs_raw_d;
    logic            ls_q, ls_d;
    logic            fs_q, fs_d;

    logic            w_h_active;
    logic            w_v_active;
    logic            w_visible;
    strobe_t         w_strobe_in;
    strobe_t         w_strobe_out;

    assign w_h_active = (h_cnt_q >= c_h_act_beg) && (h_cnt_q < c_h_act_end);
    assign w_v_active = (v_cnt_q >= c_v_act_beg) && (v_cnt_q < c_v_act_end);
    assign w_visible  = w_h_active && w_v_active;

    always_comb begin
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        de_d     = de_q;
        hs_raw_d = hs_raw_q;
        vs_raw_d = vs_raw_q;
        ls_d     = 1'b0;
        fs_d     = 1'b0;
        if (enable) begin
            if (h_cnt_q == c_h_last) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == c_v_last) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
            // Coordinates are derived from the pre-increment count, giving latency 1.
            xpos_d   = w_visible ? xcoord_t'(h_cnt_q - c_h_act_beg) : '0;
            ypos_d   = w_visible ? ycoord_t'(v_cnt_q - c_v_act_beg) : '0;
            de_d     = w_visible;
            hs_raw_d = !(h_cnt_q < c_h_sync_end);
            vs_raw_d = !(v_cnt_q < c_v_sync_end);
            ls_d     = w_v_active && (h_cnt_q == c_h_act_beg);
            fs_d     = w_v_active && (h_cnt_q == c_h_act_beg) && (v_cnt_q == c_v_act_beg);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            xpos_q   <= '0;
            ypos_q   <= '0;
            de_q     <= 1'b0;
            hs_raw_q <= 1'b1;
            vs_raw_q <= 1'b1;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            de_q     <= de_d;
            hs_raw_q <= hs_raw_d;
            vs_raw_q <= vs_raw_d;
            ls_q     <= ls_d;
            fs_q     <= fs_d;
        end
    end

    assign w_strobe_in = '{hsync_n: hs_raw_q, vsync_n: vs_raw_q, data_en: de_q};

    sync_delay_line #(
        .WIDTH   ($bits(strobe_t)),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (STROBE_RST)
    ) u_sync_delay_line (
        .clk    (clk),
        .reset  (reset),
        .en_i   (enable),
        .data_i (w_strobe_in),
        .data_o (w_strobe_out)
    );

    assign Xpos        = xpos_q;
    assign Ypos        = ypos_q;
    assign data_en     = de_q;
    assign data_en_dly = w_strobe_out.data_en;
    assign hsync_n     = w_strobe_out.hsync_n;
    assign vsync_n     = w_strobe_out.vsync_n;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_mtl_timing_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_mtl_timing_gen                                                |
// | Purpose  : Randomized self-checking bench against a raster position model.  |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_mtl_timing_gen;
    import mtl_pkg::*;

    localparam int c_n_dut = 4;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic enable = 1'b0;

    always #5 clk = ~clk;

    logic [10:0] x_w   [c_n_dut];
    logic [9:0]  y_w   [c_n_dut];
    logic        de_w  [c_n_dut];
    logic        ded_w [c_n_dut];
    logic        hs_w  [c_n_dut];
    logic        vs_w  [c_n_dut];
    logic        ls_w  [c_n_dut];
    logic        fs_w  [c_n_dut];

    // Per instance: ha, hf, hs, hb, va, vf, vs, vb, pipe delay.
    int cfg [c_n_dut][9] = '{
        '{800, 210, 30, 16, 480, 22, 13, 10, 2},
        '{800, 210, 30, 16, 480, 22, 13, 10, 0},
        '{800, 210, 30, 16, 480, 22, 13, 10, 7},
        '{8,   3,   2,  2,  4,   2,  1,  2,  1}
    };

    mtl_timing_gen #(.PIPE_DLY(2)) u_dut_p2 (
        .clk(clk), .reset(reset), .enable(enable), .Xpos(x_w[0]), .Ypos(y_w[0]),
        .data_en(de_w[0]), .data_en_dly(ded_w[0]), .hsync_n(hs_w[0]), .vsync_n(vs_w[0]),
        .line_start(ls_w[0]), .frame_start(fs_w[0]));

    mtl_timing_gen #(.PIPE_DLY(0)) u_dut_p0 (
        .clk(clk), .reset(reset), .enable(enable), .Xpos(x_w[1]), .Ypos(y_w[1]),
        .data_en(de_w[1]), .data_en_dly(ded_w[1]), .hsync_n(hs_w[1]), .vsync_n(vs_w[1]),
        .line_start(ls_w[1]), .frame_start(fs_w[1]));

    mtl_timing_gen #(.PIPE_DLY(7)) u_dut_p7 (
        .clk(clk), .reset(reset), .enable(enable), .Xpos(x_w[2]), .Ypos(y_w[2]),
        .data_en(de_w[2]), .data_en_dly(ded_w[2]), .hsync_n(hs_w[2]), .vsync_n(vs_w[2]),
        .line_start(ls_w[2]), .frame_start(fs_w[2]));

    // Tiny raster so line and frame wraps happen many times within the run.
    mtl_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(3), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(2), .V_SYNC(1), .V_BACK(2), .PIPE_DLY(1)
    ) u_dut_small (
        .clk(clk), .reset(reset), .enable(enable), .Xpos(x_w[3]), .Ypos(y_w[3]),
        .data_en(de_w[3]), .data_en_dly(ded_w[3]), .hsync_n(hs_w[3]), .vsync_n(vs_w[3]),
        .line_start(ls_w[3]), .frame_start(fs_w[3]));

    typedef struct {
        int x; int y; int de; int hs; int vs; int ls; int fs;
    } exp_t;

    int     n_chk    = 0;
    int     n_err    = 0;
    int     cur_dut  = 0;
    longint n_en     = 0;
    bit     last_en  = 1'b0;
    int     cyc      = 0;
    int     first_hs = -1;
    int     first_fs = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: observed %0d expected %0d (t=%0t)", tag, cur_dut, got, exp, $time);
        end
    endtask

    // Panel levels and coordinates seen while the raster sits at pixel index p.
    function automatic exp_t raw_at(input longint p, input int k);
        exp_t e;
        int ht, vt, h, v, h0, v0;
        bit hv, vv;
        ht = cfg[k][0] + cfg[k][1] + cfg[k][2] + cfg[k][3];
        vt = cfg[k][4] + cfg[k][5] + cfg[k][6] + cfg[k][7];
        h  = int'(p % ht);
        v  = int'((p / ht) % vt);
        h0 = cfg[k][2] + cfg[k][3];
        v0 = cfg[k][6] + cfg[k][7];
        hv = (h >= h0) && (h < h0 + cfg[k][0]);
        vv = (v >= v0) && (v < v0 + cfg[k][4]);
        e.de = (hv && vv) ? 1 : 0;
        e.x  = (e.de == 1) ? h - h0 : 0;
        e.y  = (e.de == 1) ? v - v0 : 0;
        e.hs = (h < cfg[k][2]) ? 0 : 1;
        e.vs = (v < cfg[k][6]) ? 0 : 1;
        e.ls = (vv && h == h0) ? 1 : 0;
        e.fs = (e.ls == 1 && v == v0) ? 1 : 0;
        return e;
    endfunction

    task automatic check_dut(input int k);
        exp_t e;
        exp_t d;
        int   dly;
        dly = cfg[k][8];
        e   = '{x: 0, y: 0, de: 0, hs: 1, vs: 1, ls: 0, fs: 0};
        d   = e;
        if (n_en > 0)   e = raw_at(n_en - 1, k);
        if (n_en > dly) d = raw_at(n_en - 1 - dly, k);
        if (!(n_en > 0 && last_en)) begin
            e.ls = 0;
            e.fs = 0;
        end
        cur_dut = k;
        chk("xpos",        32'(x_w[k]),   e.x);
        chk("ypos",        32'(y_w[k]),   e.y);
        chk("data_en",     32'(de_w[k]),  e.de);
        chk("line_start",  32'(ls_w[k]),  e.ls);
        chk("frame_start", 32'(fs_w[k]),  e.fs);
        chk("data_en_dly", 32'(ded_w[k]), d.de);
        chk("hsync_n",     32'(hs_w[k]),  d.hs);
        chk("vsync_n",     32'(vs_w[k]),  d.vs);
    endtask

    task automatic check_all();
        for (int k = 0; k < c_n_dut; k++) check_dut(k);
        cur_dut = 0;
    endtask

    task automatic step(input bit en, input bit rst_v);
        @(negedge clk);
        enable = en;
        reset  = rst_v;
        @(posedge clk);
        if (rst_v) begin
            n_en    = 0;
            last_en = 1'b0;
            cyc     = 0;
        end else begin
            last_en = en;
            if (en) begin
                n_en++;
                cyc++;
            end
        end
        #1;
        check_all();
        if (!rst_v && first_hs < 0 && hs_w[0] === 1'b0) first_hs = cyc;
        if (!rst_v && first_fs < 0 && fs_w[0] === 1'b1) first_fs = cyc;
    endtask

    initial begin
        // Reset must take effect before any clock edge arrives.
        #2 reset = 1'b1;
        #1 check_all();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        for (int i = 0; i < 26 * 1056; i++) step(1'b1, 1'b0);
        chk("first_hsync_low", first_hs, 3);
        chk("first_frame_start", first_fs, 23 * 1056 + 47);

        for (int i = 0; i < 1056 && (n_en % 1056) != 447; i++) step(1'b1, 1'b0);
        chk("pause_xpos", 32'(x_w[0]), 400);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("resume_xpos", 32'(x_w[0]), 401);

        for (int i = 0; i < 4000; i++) step(($urandom_range(0, 4) != 0), 1'b0);

        for (int i = 0; i < 1056 && (n_en % 1056) != 600; i++) step(1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        n_en     = 0;
        last_en  = 1'b0;
        cyc      = 0;
        first_hs = -1;
        check_all();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 1100; i++) step(1'b1, 1'b0);
        chk("post_reset_hsync_low", first_hs, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mtl_timing_gen.md
# mtl_timing_gen

Raster timing generator for the 800×480 MTL LCD panel (1056×525 total raster). It produces the active-area pixel coordinates `Xpos`/`Ypos` consumed by the pixel-colour stages (line/shape renderers). It also drives the panel sync and data-enable strobes. Those strobes are delayed by a programmable number of cycles so they stay aligned with the downstream colour registers.

## Interface
- `H_ACTIVE`, 800, visible pixels per line
- `H_FRONT`, 210, horizontal front porch (cycles)
- `H_SYNC`, 30, hsync pulse width
- `H_BACK`, 16, horizontal back porch; line total = 1056
- `V_ACTIVE`, 480, visible lines per frame
- `V_FRONT`, 22, vertical front porch (lines)
- `V_SYNC`, 13, vsync pulse width (lines)
- `V_BACK`, 10, vertical back porch; frame total = 525
- `PIPE_DLY`, 2, cycles of delay on `hsync_n`/`vsync_n`/`data_en_dly` relative to `Xpos`/`Ypos` (legal range 0..7)

Ports:
- `clk` in 1: pixel clock; all logic is on the rising edge
- `reset` in 1: asynchronous, active-high
- `enable` in 1: count enable; when low the raster holds its position
- `Xpos` out 11: active-area column 0..H_ACTIVE-1; 0 outside the active area
- `Ypos` out 10: active-area row 0..V_ACTIVE-1; 0 outside the active area
- `data_en` out 1: high while `Xpos`/`Ypos` is a visible pixel (undelayed)
- `data_en_dly` out 1: `data_en` delayed by PIPE_DLY
- `hsync_n` out 1: active-low hsync, delayed by PIPE_DLY
- `vsync_n` out 1: active-low vsync, delayed by PIPE_DLY
- `line_start` out 1: one-cycle pulse with `Xpos`=0 on the first active pixel of each active line
- `frame_start` out 1: one-cycle pulse coincident with `line_start` of row 0

## Operation
- Internal counters:
  - `h_cnt` runs 0..1055.
  - `v_cnt` runs 0..524 and increments when `h_cnt` wraps 1055→0.
  - `v_cnt` wraps 524→0 on that same edge.
- Horizontal regions by `h_cnt`:
  - sync: [0, H_SYNC)
  - back porch: [H_SYNC, H_SYNC+H_BACK)
  - active: [46, 846)
  - front porch: [846, 1056)
- Vertical regions by `v_cnt`: same order; active lines are [23, 503).
- Visible pixel: both counters are in their active regions.
- On a visible pixel:
  - `Xpos` = `h_cnt`−46
  - `Ypos` = `v_cnt`−23
  - `data_en` = 1
- Outside the active area: `Xpos`, `Ypos` and `data_en` are all 0.
- Sync level:
  - raw `hsync_n` = 0 when `h_cnt` < H_SYNC
  - raw `vsync_n` = 0 when `v_cnt` < V_SYNC, over the full line width
- Delay line: a shift register of depth PIPE_DLY carries {hsync_n, vsync_n, data_en}. PIPE_DLY=0 is a pass-through of the registered raw values.
- `enable` low:
  - counters, position outputs and delay line all freeze and hold their current values
  - pulse outputs are forced to 0
  - on re-enable, counting resumes from the held position
- Arithmetic: coordinate subtraction is unsigned at counter width, then truncated to the port width. Localparam totals are derived from the parameters, never hard-coded.

## Timing
- Reset values:
  - `h_cnt`=0, `v_cnt`=0
  - `Xpos`=0, `Ypos`=0
  - `data_en`=0, `data_en_dly`=0
  - `hsync_n`=1, `vsync_n`=1, including every delay-line stage
  - `line_start`=0, `frame_start`=0
- All outputs are registered. Position outputs and `data_en` reflect the counter values of the previous cycle (latency 1).
- Sync and `data_en_dly` outputs have latency 1+PIPE_DLY.
- First cycle after reset release with `enable`=1: `hsync_n` goes low after PIPE_DLY+1 cycles.
- First `frame_start` occurs at cycle 23·1056+46+1 after release.
- Reset asserted mid-frame: all state clears immediately (asynchronous reset). Counting restarts at `h_cnt`=0 on the first enabled edge after deassertion.
- Simultaneous line and frame wrap (`h_cnt`=1055, `v_cnt`=524): both counters go to 0 on the same edge.

## Structure
- Shared package `mtl_pkg`:
  - MTL timing defaults (1056/525 totals, porch and sync widths)
  - coordinate widths: X=11, Y=10
  - typedefs `xcoord_t`, `ycoord_t`
- Downstream renderers import `xcoord_t`/`ycoord_t` from `mtl_pkg`.
- One sub-module: `sync_delay_line`, parameterized width and depth, with reset value supplied as a parameter; it holds the PIPE_DLY shift register.

## Test plan
- Reset release, `enable`=1, PIPE_DLY=2:
  - `hsync_n` low for exactly 30 cycles starting at cycle 3, period 1056
  - `vsync_n` low for exactly 13·1056 cycles, period 525·1056
- Full frame scan:
  - `data_en` high for exactly 384000 cycles per frame
  - `Xpos` runs 0..799 contiguously per line and `Ypos` runs 0..479
  - `Xpos`=`Ypos`=0 whenever `data_en`=0
- Pulse check:
  - `frame_start` fires once per frame, with `Xpos`=0 and `Ypos`=0
  - `line_start` fires 480 times per frame
- `enable` low for 100 cycles while `Xpos`=400, `Ypos`=200:
  - all outputs hold, pulses stay 0
  - after re-enable the next `Xpos` is 401
- Reset asserted at `h_cnt`≈600, `v_cnt`≈300:
  - outputs take their reset values without waiting for a clock edge
  - post-release timing matches the first scenario
- PIPE_DLY=0 and PIPE_DLY=7:
  - `data_en_dly` equals `data_en` delayed by exactly 0 and 7 cycles respectively
  - sync edges shift by the same amount
